// File: rtl/pdh_capture_pkg.sv
// Types and widths shared by the capture sequencer and the BRAM capture controller.
package pdh_capture_pkg;

  localparam int unsigned DW   = 14;
  localparam int unsigned DECW = 22;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    FIRE    = 3'd2,
    CAPTURE = 3'd3,
    HOLDOFF = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    IMMEDIATE = 2'd0,
    LEVEL     = 2'd1,
    EDGE      = 2'd2,
    RESERVED  = 2'd3
  } trig_mode_t;

endpackage

// File: rtl/trig_crossing_detector.sv
// Level / edge threshold detector on the signed PDH trigger sample.
module trig_crossing_detector
  import pdh_capture_pkg::*;
(
  input  logic          pdh_clk,
  input  logic          rst_i,
  input  logic          edge_mode,
  input  logic          slope,
  input  logic [DW-1:0] sample,
  input  logic [DW-1:0] level,
  output logic          fire_c
);

  logic signed [DW-1:0] prev_q;
  logic signed [DW-1:0] cur_s;
  logic signed [DW-1:0] level_s;

  // Previous sample tracks every cycle so a crossing that straddles arming still counts.
  always_ff @(posedge pdh_clk or posedge rst_i) begin
    if (rst_i) prev_q <= '0;
    else       prev_q <= $signed(sample);
  end

  always_comb begin
    cur_s   = $signed(sample);
    level_s = $signed(level);
    fire_c  = 1'b0;
    if (edge_mode) fire_c = slope ? ((prev_q > level_s) && (cur_s <= level_s))
                                  : ((prev_q < level_s) && (cur_s >= level_s));
    else           fire_c = slope ? (cur_s <= level_s) : (cur_s >= level_s);
  end

endmodule

// File: rtl/capture_sequencer.sv
// Sequences triggered multi-shot acquisitions into the BRAM capture controller.
module capture_sequencer
  import pdh_capture_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned HOLDW       = 16
) (
  input  logic            pdh_clk,
  input  logic            rst_i,
  input  logic            cmd_start_i,
  input  logic            cmd_abort_i,
  input  logic [1:0]      mode_i,
  input  logic            trig_slope_i,
  input  logic [DW-1:0]   trig_sig_i,
  input  logic [DW-1:0]   trig_level_i,
  input  logic [7:0]      n_shots_i,
  input  logic [HOLDW-1:0] holdoff_i,
  input  logic [DECW-1:0] decimation_code_i,
  input  logic            cap_ready_i,
  output logic            cap_enable_o,
  output logic [DECW-1:0] cap_decimation_code_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [7:0]      shots_done_o,
  output logic            err_timeout_o
);

  localparam int unsigned FCW = $clog2(ACK_TIMEOUT + 1);

  state_t           state_q, state_d;
  trig_mode_t       mode_q;
  logic             slope_q;
  logic [DW-1:0]    level_q;
  logic [7:0]       n_shots_q;
  logic [HOLDW-1:0] holdoff_q;
  logic [HOLDW-1:0] hold_cnt_q, hold_cnt_d;
  logic [FCW-1:0]   fire_cnt_q, fire_cnt_d;
  logic             aborting_q, aborting_d;
  logic [7:0]       shots_d;
  logic             done_d, err_d;
  logic             latch_cmd_c;
  logic             det_fire_c;
  logic             trig_hit_c;

  trig_crossing_detector u_trig (
    .pdh_clk   (pdh_clk),
    .rst_i     (rst_i),
    .edge_mode (mode_q == EDGE),
    .slope     (slope_q),
    .sample    (trig_sig_i),
    .level     (level_q),
    .fire_c    (det_fire_c)
  );

  assign trig_hit_c = ((mode_q == LEVEL) || (mode_q == EDGE)) ? det_fire_c : 1'b1;

  always_ff @(posedge pdh_clk or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    latch_cmd_c = 1'b0;
    aborting_d  = aborting_q;
    fire_cnt_d  = fire_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    shots_d     = shots_done_o;
    done_d      = done_o;
    err_d       = err_timeout_o;
    case (state_q)
      IDLE: begin
        // Abort in the same cycle drops the start.
        if (cmd_start_i && !cmd_abort_i) begin
          latch_cmd_c = 1'b1;
          aborting_d  = 1'b0;
          shots_d     = 8'd0;
          done_d      = 1'b0;
          err_d       = 1'b0;
          state_d     = ARM;
        end
      end
      ARM: begin
        if (cmd_abort_i) state_d = IDLE;
        else if (cap_ready_i && trig_hit_c) begin
          fire_cnt_d = '0;
          state_d    = FIRE;
        end
      end
      FIRE: begin
        if (cmd_abort_i) begin
          aborting_d = 1'b1;
          state_d    = CAPTURE;
        end else if (!cap_ready_i) begin
          state_d = CAPTURE;
        end else if (fire_cnt_q == FCW'(ACK_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          fire_cnt_d = fire_cnt_q + FCW'(1);
        end
      end
      CAPTURE: begin
        if (cap_ready_i) begin
          if (aborting_q || cmd_abort_i) begin
            state_d = IDLE;
          end else begin
            shots_d = shots_done_o + 8'd1;
            if (shots_d == n_shots_q) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else if (holdoff_q == '0) begin
              state_d = ARM;
            end else begin
              hold_cnt_d = '0;
              state_d    = HOLDOFF;
            end
          end
        end else if (cmd_abort_i) begin
          aborting_d = 1'b1;
        end
      end
      HOLDOFF: begin
        if (cmd_abort_i) state_d = IDLE;
        else if (hold_cnt_q == holdoff_q - HOLDW'(1)) state_d = ARM;
        else hold_cnt_d = hold_cnt_q + HOLDW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Command latch, counters and registered status outputs.
  always_ff @(posedge pdh_clk or posedge rst_i) begin
    if (rst_i) begin
      mode_q                <= IMMEDIATE;
      slope_q               <= 1'b0;
      level_q               <= '0;
      n_shots_q             <= 8'd1;
      holdoff_q             <= '0;
      hold_cnt_q            <= '0;
      fire_cnt_q            <= '0;
      aborting_q            <= 1'b0;
      cap_enable_o          <= 1'b0;
      cap_decimation_code_o <= DECW'(1);
      busy_o                <= 1'b0;
      done_o                <= 1'b0;
      shots_done_o          <= 8'd0;
      err_timeout_o         <= 1'b0;
    end else begin
      if (latch_cmd_c) begin
        mode_q                <= trig_mode_t'(mode_i);
        slope_q               <= trig_slope_i;
        level_q               <= trig_level_i;
        n_shots_q             <= (n_shots_i == 8'd0) ? 8'd1 : n_shots_i;
        holdoff_q             <= holdoff_i;
        cap_decimation_code_o <= decimation_code_i;
      end
      hold_cnt_q    <= hold_cnt_d;
      fire_cnt_q    <= fire_cnt_d;
      aborting_q    <= aborting_d;
      cap_enable_o  <= (state_d == FIRE);
      busy_o        <= (state_d != IDLE);
      done_o        <= done_d;
      shots_done_o  <= shots_d;
      err_timeout_o <= err_d;
    end
  end

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
Schedules acquisitions into the BRAM capture controller on pdh_clk.
- Latches a capture command and waits for a selectable trigger on the PDH error signal.
- Pulses the capture controller's enable, tracks its ready handshake, and repeats for N shots with a holdoff between shots.
- Reports busy/done/shot-count/timeout status to the AXI register bank. The bank synchronises these outputs; it does not synchronise the trigger inputs.

Parameters:
DW, 14, width of signed trigger sample and level
DECW, 22, decimation code width (matches capture controller)
ACK_TIMEOUT, 16, max pdh_clk cycles from enable assert to cap_ready_i low
HOLDW, 16, holdoff counter width

Ports:
pdh_clk  in  1  capture/PDH clock; all logic on its rising edge
rst_i  in  1  asynchronous, active-high reset
cmd_start_i  in  1  single-cycle start pulse (already in pdh_clk domain)
cmd_abort_i  in  1  single-cycle abort pulse
mode_i  in  2  0 immediate, 1 level, 2 edge, 3 reserved (treated as immediate)
trig_slope_i  in  1  0 rising/above, 1 falling/below
trig_sig_i  in  DW  signed trigger sample, valid every cycle
trig_level_i  in  DW  signed trigger threshold
n_shots_i  in  8  number of captures per command; 0 treated as 1
holdoff_i  in  HOLDW  idle cycles between shot completion and re-arm
decimation_code_i  in  DECW  decimation for all shots of the command
cap_ready_i  in  1  capture controller idle/ready
cap_enable_o  out  1  enable to capture controller (rising edge starts a shot)
cap_decimation_code_o  out  DECW  latched decimation code
busy_o  out  1  command in progress
done_o  out  1  sticky: last command completed all shots
shots_done_o  out  8  completed shots of current/last command
err_timeout_o  out  1  sticky: capture controller did not acknowledge

Behaviour:
- Reset values: every output is 0; state is IDLE; cap_decimation_code_o resets to 1.
- At cmd_start_i in IDLE, latch mode, slope, level, n_shots, holdoff and decimation code.
  - Clear done_o, err_timeout_o and shots_done_o.
  - Go to ARM.
- cmd_start_i is ignored when the state is not IDLE.
- States:
  - IDLE: busy_o=0.
  - ARM: wait for the trigger, and also require cap_ready_i=1.
    - Immediate mode fires on the first cycle in ARM with ready=1.
    - Transition to FIRE happens on the cycle the trigger condition is true.
  - FIRE: cap_enable_o=1.
    - Exit to CAPTURE on the first cycle cap_ready_i=0; cap_enable_o drops the next cycle.
    - Count cycles in FIRE. If the count reaches ACK_TIMEOUT: set err_timeout_o, deassert enable, go to IDLE, leave done_o=0.
  - CAPTURE: wait for cap_ready_i=1, then increment shots_done_o.
    - If shots_done equals the latched n_shots: set done_o and go to IDLE.
    - Otherwise go to HOLDOFF.
  - HOLDOFF: count holdoff cycles, then go to ARM. holdoff=0 means ARM on the next cycle.
- Trigger rules (registered previous sample p, current sample c, level L, signed compare):
  - level mode: slope0 fires when c>=L; slope1 fires when c<=L.
  - edge mode: slope0 fires when p<L and c>=L; slope1 fires when p>L and c<=L.
  - p resets to 0 and updates every cycle, including outside ARM. An edge spanning ARM entry therefore counts.
- Abort:
  - In ARM or HOLDOFF: go to IDLE the next cycle; done_o=0.
  - In FIRE or CAPTURE: deassert enable, wait for cap_ready_i=1, then go to IDLE. The in-flight shot is not counted.
  - In IDLE: no effect.
  - Abort and start in the same cycle: abort wins, the start is dropped.
- busy_o=1 in every state except IDLE.
- Async reset mid-capture returns to IDLE. The capture controller is not reset by this block.

Decomposition:
- Shared package pdh_capture_pkg holds:
  - the state_t enum (IDLE, ARM, FIRE, CAPTURE, HOLDOFF);
  - the trig_mode_t enum (IMMEDIATE, LEVEL, EDGE, RESERVED);
  - DECW and DW constants, shared with the capture controller.
- One sub-module, trig_crossing_detector: prev-sample register plus the level/edge/slope compare. It outputs a 1-bit fire signal, combinational from c and registered p.

Test Plan:
- Immediate, n_shots=1, dec=4, model controller acks 2 cycles after enable → one enable pulse, shots_done_o=1, done_o=1, busy_o=0.
- Edge rising, L=100, trig ramps -50→+200 by 10/cycle → enable asserts exactly one cycle after the first sample >=100; a level already above 100 at start does not fire until it re-crosses.
- n_shots=3, holdoff=5 → three enables; 5 idle cycles between each ready-high and the next ARM; shots_done_o steps 1,2,3.
- Controller never drops ready → err_timeout_o=1 after 16 FIRE cycles, done_o=0, busy_o=0, enable low.
- Abort during CAPTURE of shot 2 of 4 → enable low, IDLE after ready returns, shots_done_o=1, done_o=0; start+abort in the same cycle leaves busy_o=0.
- Assert rst_i asynchronously mid-FIRE → cap_enable_o=0 and busy_o=0 immediately; cap_decimation_code_o=1.
